// File: rtl/freq_meter.sv
// ============================================================================
// Module   : freq_meter
// Purpose  : Counts rising edges of an asynchronous sig_in over a GATE-cycle
//            window of clk_in. Define FREQ_METER_PERIOD_MEAS_EN to add
//            period measurement in clk_in cycles.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module freq_meter #(
    parameter int GATE  = 50000000,
    parameter int CNT_W = 32
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             sig_in,
    input  logic             en,
    output logic [CNT_W-1:0] freq_count,
    output logic             freq_valid,
    output logic             freq_sat,
    output logic [CNT_W-1:0] period,
    output logic             period_valid
);

    // Window counter only has to reach GATE-1, independent of CNT_W.
    localparam int                 c_WIN_W    = (GATE > 2) ? $clog2(GATE) : 1;
    localparam logic [c_WIN_W-1:0] c_WIN_LAST = c_WIN_W'(GATE - 1);
    localparam logic [CNT_W-1:0]   c_CNT_MAX  = '1;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_GATE = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    logic               r_sync1;
    logic               r_sync2;
    logic               r_hist;
    logic               r_primed;
    logic               w_edge;
    logic [1:0]         r_state;
    logic [c_WIN_W-1:0] r_win_cnt;
    logic [CNT_W-1:0]   r_edge_cnt;
    logic [CNT_W-1:0]   w_edge_next;

    // Synchronizer stays unreset so a level held through reset is already
    // settled when reset releases; r_primed then masks the first compare.
    always_ff @(posedge clk_in) begin
        r_sync1 <= sig_in;
        r_sync2 <= r_sync1;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            r_hist   <= 1'b0;
            r_primed <= 1'b0;
        end else begin
            r_hist   <= r_sync2;
            r_primed <= 1'b1;
        end
    end

    assign w_edge      = r_primed & r_sync2 & ~r_hist;
    assign w_edge_next = (w_edge && (r_edge_cnt != c_CNT_MAX)) ?
                         r_edge_cnt + CNT_W'(1) : r_edge_cnt;

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            r_state    <= c_ST_IDLE;
            r_win_cnt  <= '0;
            r_edge_cnt <= '0;
            freq_count <= '0;
            freq_valid <= 1'b0;
            freq_sat   <= 1'b0;
        end else begin
            freq_valid <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    r_win_cnt  <= '0;
                    r_edge_cnt <= '0;
                    if (en) begin
                        r_state <= c_ST_GATE;
                    end
                end
                c_ST_GATE: begin
                    if (!en) begin
                        r_state    <= c_ST_IDLE;
                        r_win_cnt  <= '0;
                        r_edge_cnt <= '0;
                    end else begin
                        r_edge_cnt <= w_edge_next;
                        if (r_win_cnt == c_WIN_LAST) begin
                            // Result is published on entry to DONE so the
                            // valid pulse coincides with the DONE cycle.
                            r_state    <= c_ST_DONE;
                            freq_count <= w_edge_next;
                            freq_sat   <= (w_edge_next == c_CNT_MAX);
                            freq_valid <= 1'b1;
                        end else begin
                            r_win_cnt <= r_win_cnt + c_WIN_W'(1);
                        end
                    end
                end
                c_ST_DONE: begin
                    r_win_cnt  <= '0;
                    r_edge_cnt <= (en && w_edge) ? CNT_W'(1) : '0;
                    r_state    <= en ? c_ST_GATE : c_ST_IDLE;
                end
                default: begin
                    r_state    <= c_ST_IDLE;
                    r_win_cnt  <= '0;
                    r_edge_cnt <= '0;
                end
            endcase
        end
    end

`ifdef FREQ_METER_PERIOD_MEAS_EN
    logic [CNT_W-1:0] r_per_cnt;
    logic             r_seen;

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            r_per_cnt    <= '0;
            r_seen       <= 1'b0;
            period       <= '0;
            period_valid <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            if (w_edge) begin
                r_per_cnt <= CNT_W'(1);
                r_seen    <= 1'b1;
                if (r_seen) begin
                    period       <= r_per_cnt;
                    period_valid <= 1'b1;
                end
            end else if (r_per_cnt != c_CNT_MAX) begin
                r_per_cnt <= r_per_cnt + CNT_W'(1);
            end
        end
    end
`else
    assign period       = '0;
    assign period_valid = 1'b0;
`endif

endmodule

`default_nettype wire
